// File: rtl/immgen_stage.sv
// immgen_stage: decodes the immediate of an RV32/RV64 instruction and
// queues it with its format tag and raw word in a small in-order FIFO.
// Parameters: XLEN (32 or 64), DEPTH (2 or 4).
// Optional macro IMMGEN_CSR_ZIMM_EN: decode the SYSTEM opcode (CSR
// immediate Z format and register-form CSR I immediates).
module immgen_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_inst_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_imm_o,
  output logic [2:0]      out_fmt_o,
  output logic [31:0]     out_inst_o
);

  localparam int PW = (DEPTH == 4) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  generate
    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
      $error("immgen_stage: XLEN must be 32 or 64");
    end
    if (!(DEPTH == 2 || DEPTH == 4)) begin : g_bad_depth
      $error("immgen_stage: DEPTH must be 2 or 4");
    end
  endgenerate

  // Sign-extend a 32-bit immediate to the datapath width.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = signed'(v);
    return XLEN'(s);
  endfunction

  logic [31:0]     dec_raw;
  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            i31;

  assign i31 = in_inst_i[31];

  // Combinational immediate decode of the incoming instruction.
  always_comb begin
    dec_raw = '0;
    dec_fmt = FMT_NONE;
    case (in_inst_i[6:0])
      7'b1100111, 7'b0000011, 7'b0010011: begin
        dec_fmt = FMT_I;
        dec_raw = {{20{i31}}, in_inst_i[31:20]};
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_fmt = FMT_I;
          dec_raw = {{20{i31}}, in_inst_i[31:20]};
        end
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_raw = {{20{i31}}, in_inst_i[31:25], in_inst_i[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_raw = {{19{i31}}, i31, in_inst_i[7], in_inst_i[30:25],
                   in_inst_i[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        dec_raw = {in_inst_i[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_raw = {{11{i31}}, i31, in_inst_i[19:12], in_inst_i[20],
                   in_inst_i[30:21], 1'b0};
      end
`ifdef IMMGEN_CSR_ZIMM_EN
      7'b1110011: begin
        case (in_inst_i[14:12])
          3'b101, 3'b110, 3'b111: begin
            dec_fmt = FMT_Z;
            dec_raw = {27'b0, in_inst_i[19:15]};
          end
          3'b001, 3'b010, 3'b011: begin
            dec_fmt = FMT_I;
            dec_raw = {{20{i31}}, in_inst_i[31:20]};
          end
          default: begin
            dec_fmt = FMT_NONE;
            dec_raw = '0;
          end
        endcase
      end
`endif
      default: begin
        dec_fmt = FMT_NONE;
        dec_raw = '0;
      end
    endcase
    dec_imm = sext32(dec_raw);
  end

`ifndef IMMGEN_CSR_ZIMM_EN
  // funct3 only matters for the CSR decode.
  logic unused_funct3;
  assign unused_funct3 = ^in_inst_i[14:12];
`endif

  logic [XLEN-1:0] imm_mem_q  [DEPTH];
  logic [2:0]      fmt_mem_q  [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign in_ready_o  = (count_q < DEPTH_C);
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Next-state for pointers and occupancy; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload storage; written on an accepted, non-flushed push.
  always_ff @(posedge clk) begin
    if (push && !flush_i) begin
      imm_mem_q[wr_ptr_q]  <= dec_imm;
      fmt_mem_q[wr_ptr_q]  <= dec_fmt;
      inst_mem_q[wr_ptr_q] <= in_inst_i;
    end
  end

  // Head entry drives the outputs; an empty buffer reads as zero.
  always_comb begin
    out_imm_o  = '0;
    out_fmt_o  = FMT_NONE;
    out_inst_o = '0;
    if (out_valid_o) begin
      out_imm_o  = imm_mem_q[rd_ptr_q];
      out_fmt_o  = fmt_mem_q[rd_ptr_q];
      out_inst_o = inst_mem_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_immgen_stage.sv
// Bench for immgen_stage: table of instruction vectors through a
// scoreboard on an XLEN=32/DEPTH=2 instance, plus an XLEN=64/DEPTH=4
// instance for the 64-bit immediates.
module tb_immgen_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic        in_ready, out_valid;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [31:0] out_inst;

  logic        v64, r64, rdy64, ov64;
  logic [31:0] inst64, oinst64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;

  immgen_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_inst_i(in_inst),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_imm_o(out_imm), .out_fmt_o(out_fmt), .out_inst_o(out_inst)
  );

  immgen_stage #(.XLEN(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst(rst), .flush_i(1'b0),
    .in_valid_i(v64), .in_ready_o(rdy64), .in_inst_i(inst64),
    .out_valid_o(ov64), .out_ready_i(r64),
    .out_imm_o(imm64), .out_fmt_o(fmt64), .out_inst_o(oinst64)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [2:0]  fmt;
  } vec_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } vec64_t;

  vec_t   vecs [16];
  vec64_t v64s [5];
  vec_t   sbq [$];
  vec_t   cur_in;
  int     checks = 0;
  int     errors = 0;
  bit     last_push;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_inst = v.inst;
    cur_in  = v;
  endtask

  // One clock: sample handshakes away from the edge, update scoreboard.
  task automatic cycle();
    bit   fin, fout;
    vec_t e;
    #1;
    fin  = in_valid && in_ready;
    fout = out_valid && out_ready;
    if (fout) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got inst 0x%0h with empty scoreboard", out_inst);
      end else begin
        e = sbq.pop_front();
        chk("out_inst", 64'(out_inst), 64'(e.inst));
        chk("out_imm",  64'(out_imm),  64'(e.imm));
        chk("out_fmt",  64'(out_fmt),  64'(e.fmt));
      end
    end
    last_push = fin && !flush;
    if (last_push) sbq.push_back(cur_in);
    if (flush) sbq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input vec_t v, input bit rand_ready);
    int budget;
    drive(v);
    in_valid = 1'b1;
    budget = 0;
    last_push = 1'b0;
    while (!last_push && budget < 50) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      cycle();
      budget++;
    end
    if (!last_push) chk("push_timeout", 64'(budget), 64'(0));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    out_ready = 1'b1;
    budget = 0;
    while (sbq.size() != 0 && budget < 50) begin
      cycle();
      budget++;
    end
    chk("drain_empty", 64'(sbq.size()), 64'(0));
    chk("drain_valid", 64'(out_valid), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1};
    vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3};
`ifdef IMMGEN_CSR_ZIMM_EN
    vecs[2]  = '{32'h3401D073, 32'h00000003, 3'd6};
    vecs[13] = '{32'hC0002573, 32'hFFFFFC00, 3'd1};
`else
    vecs[2]  = '{32'h3401D073, 32'h00000000, 3'd0};
    vecs[13] = '{32'hC0002573, 32'h00000000, 3'd0};
`endif
    vecs[3]  = '{32'h12345037, 32'h12345000, 3'd4};
    vecs[4]  = '{32'h800002B7, 32'h80000000, 3'd4};
    vecs[5]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2};
    vecs[6]  = '{32'h0080006F, 32'h00000008, 3'd5};
    vecs[7]  = '{32'hFFDFF0EF, 32'hFFFFFFFC, 3'd5};
    vecs[8]  = '{32'h00001017, 32'h00001000, 3'd4};
    vecs[9]  = '{32'h7FF02083, 32'h000007FF, 3'd1};
    vecs[10] = '{32'h000080E7, 32'h00000000, 3'd1};
    vecs[11] = '{32'h002081B3, 32'h00000000, 3'd0};
    vecs[12] = '{32'h0010009B, 32'h00000000, 3'd0};
    vecs[14] = '{32'h00000073, 32'h00000000, 3'd0};
    vecs[15] = '{32'h00209093, 32'h00000002, 3'd1};

    v64s[0] = '{32'h800002B7, 64'hFFFFFFFF80000000, 3'd4};
    v64s[1] = '{32'h0010009B, 64'h0000000000000001, 3'd1};
    v64s[2] = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3};
    v64s[3] = '{32'h0080006F, 64'h0000000000000008, 3'd5};
    v64s[4] = '{32'h12345037, 64'h0000000012345000, 3'd4};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; cur_in = '0;
    v64 = 1'b0; r64 = 1'b1; inst64 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_out_imm",   64'(out_imm),   64'(0));
    chk("rst_out_fmt",   64'(out_fmt),   64'(0));
    chk("rst_out_inst",  64'(out_inst),  64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // One-cycle latency into an empty buffer
    drive(vecs[0]);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("lat_valid", 64'(out_valid), 64'(1));
    chk("lat_imm",   64'(out_imm),   64'(32'hFFFFFFFF));
    chk("lat_fmt",   64'(out_fmt),   64'(1));
    drain();

    // Table of decode vectors with random back-pressure
    for (int i = 0; i < 16; i++) push_one(vecs[i], 1'b1);
    drain();

    // Fill with out_ready low: third instruction held off
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(vecs[3]); cycle();
    drive(vecs[4]); cycle();
    chk("full_in_ready", 64'(in_ready), 64'(0));
    drive(vecs[5]);
    for (int k = 0; k < 3; k++) cycle();
    chk("full_held_count", 64'(sbq.size()), 64'(2));
    chk("full_held_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    push_one(vecs[5], 1'b0);
    drain();

    // Full buffer with both sides active: streaming keeps order
    out_ready = 1'b0;
    push_one(vecs[6], 1'b0);
    push_one(vecs[7], 1'b0);
    out_ready = 1'b1;
    for (int i = 8; i < 12; i++) push_one(vecs[i], 1'b0);
    drain();

    // Flush with a simultaneous push and pop
    out_ready = 1'b0;
    push_one(vecs[1], 1'b0);
    drive(vecs[2]);
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush1_valid", 64'(out_valid), 64'(0));
    chk("flush1_ready", 64'(in_ready),  64'(1));
    chk("flush1_inst",  64'(out_inst),  64'(0));

    // Flush a full buffer while a push is offered
    push_one(vecs[3], 1'b0);
    push_one(vecs[4], 1'b0);
    drive(vecs[5]);
    in_valid = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_valid", 64'(out_valid), 64'(0));
    chk("flush2_ready", 64'(in_ready),  64'(1));
    push_one(vecs[9], 1'b0);
    drain();

    // Reset asserted mid-stream takes effect without a clock edge
    out_ready = 1'b0;
    push_one(vecs[6], 1'b0);
    push_one(vecs[7], 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("amid_rst_valid", 64'(out_valid), 64'(0));
    chk("amid_rst_ready", 64'(in_ready),  64'(1));
    chk("amid_rst_imm",   64'(out_imm),   64'(0));
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(out_valid), 64'(0));
    push_one(vecs[15], 1'b0);
    drain();

    // XLEN=64 instance
    for (int i = 0; i < 5; i++) begin
      inst64 = v64s[i].inst;
      v64 = 1'b1;
      @(posedge clk);
      #1;
      v64 = 1'b0;
      chk("x64_valid", 64'(ov64), 64'(1));
      chk("x64_imm",   imm64,     v64s[i].imm);
      chk("x64_fmt",   64'(fmt64), 64'(v64s[i].fmt));
      chk("x64_inst",  64'(oinst64), 64'(v64s[i].inst));
      @(posedge clk);
      #1;
    end
    chk("x64_empty", 64'(ov64), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/immgen_stage.md
IMMGEN_STAGE -- requirements
Module: immgen_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of the immediate; SHALL accept only 32 or 64.
REQ-002 Parameter DEPTH, default 2, number of buffer entries; SHALL accept only 2 or 4.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 flush_i  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid_i  input  1  upstream instruction valid.
REQ-007 in_ready_o  output  1  stage can accept an instruction.
REQ-008 in_inst_i  input  32  raw instruction word.
REQ-009 out_valid_o  output  1  head entry valid.
REQ-010 out_ready_i  input  1  downstream consumes the head entry.
REQ-011 out_imm_o  output  XLEN  sign- or zero-extended immediate of the head entry.
REQ-012 out_fmt_o  output  3  immediate format of the head entry: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
REQ-013 out_inst_o  output  32  head-entry instruction, passed through unchanged.

Function
REQ-014 Push SHALL occur on a rising edge when in_valid_i and in_ready_o are both high; pop SHALL occur when out_valid_o and out_ready_i are both high.
REQ-015 Immediate SHALL be computed combinationally from in_inst_i and stored with the entry, so latency from push to out_valid_o is exactly 1 cycle into an empty buffer.
REQ-016 Opcode decode: 1100111, 0000011, 0010011 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; opcode 0011011 -> I only when XLEN=64; every other opcode -> fmt 0 with imm all zero.
REQ-017 I/S/B/J immediates SHALL be sign-extended from inst[31] to XLEN bits; B and J SHALL have bit 0 = 0.
REQ-018 U immediate SHALL be {inst[31:12], 12'b0}; when XLEN=64 it SHALL be sign-extended from inst[31].
REQ-019 Buffer SHALL be an in-order FIFO of DEPTH entries, with wrap-around read/write pointers and a count of 0..DEPTH.
REQ-020 in_ready_o SHALL be (count < DEPTH) and SHALL NOT depend combinationally on out_ready_i.
REQ-021 out_valid_o SHALL be (count != 0); the out_* data outputs SHALL come from the head entry.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged; a push is never possible when full, and a pop is never possible when empty.
REQ-023 While out_valid_o is high and out_ready_i is low, all out_* outputs SHALL hold stable.
REQ-024 When flush_i is high, count and both pointers SHALL clear to 0 at the next edge; a push and/or pop in that same cycle SHALL be discarded.
REQ-025 When count is 0, out_imm_o, out_fmt_o and out_inst_o SHALL read as 0.

Reset
REQ-026 Asserting rst SHALL immediately clear count and the pointers, drive out_valid_o to 0 and in_ready_o to 1, and make the out_* data outputs read 0.
REQ-027 Reset asserted mid-operation SHALL drop all buffered entries, with no partial pop.
REQ-028 Stored entry payloads need no reset.

Configuration
REQ-029 Macro IMMGEN_CSR_ZIMM_EN SHALL control decoding of the SYSTEM opcode 1110011.
REQ-030 With IMMGEN_CSR_ZIMM_EN defined: funct3 values 101, 110 and 111 SHALL give fmt 6 with imm = zero-extended inst[19:15]; funct3 values 001, 010 and 011 SHALL give fmt 1 with the I immediate; funct3 000 SHALL give fmt 0.
REQ-031 Without IMMGEN_CSR_ZIMM_EN: the SYSTEM opcode SHALL give fmt 0 with imm 0, and no Z-format logic SHALL be synthesised.

Verification
REQ-032 XLEN=32, push inst 0xFFF00093 (addi -1) into an empty buffer -> next cycle out_valid_o=1, out_imm_o=0xFFFFFFFF, out_fmt_o=1.
REQ-033 XLEN=64, push 0x800002B7 (lui) -> out_imm_o=0xFFFFFFFF80000000, out_fmt_o=4; push 0x0010009B (addiw) -> imm=1, fmt=1.
REQ-034 DEPTH=2, out_ready_i=0, push 3 instructions back-to-back -> in_ready_o drops after 2 pushes; the third instruction is held off; raising out_ready_i pops entries in order and never drops or duplicates one.
REQ-035 Full buffer, out_ready_i=1 and in_valid_i=1 -> one pop per cycle, count returns below DEPTH, the next push is accepted, and order is preserved.
REQ-036 Buffer holding 2 entries, assert flush_i together with a push -> next cycle out_valid_o=0 and count=0; assert rst mid-stream -> out_valid_o=0 immediately.
REQ-037 With IMMGEN_CSR_ZIMM_EN, push 0x3401D073 (csrrwi rs1-field 3) -> imm=3, fmt=6; without the macro -> imm=0, fmt=0. Push 0xFE000EE3 (beq -4) -> imm=0xFFFFFFFC, fmt=3.
